// File: rtl/bist_march_ctrl.sv
// March-style RAM BIST sequencer: write every address with the generator word, read back and compare.
// Optional BIST_ABORT_ON_FAIL_EN: stop at the first mismatch and flush the generator back to pattern 0.
module bist_march_ctrl #(
    parameter int unsigned Word_size    = 3,
    parameter int unsigned Addr_size    = 4,
    parameter int unsigned Num_patterns = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [Word_size-1:0]              word,
    output logic                              gen_next,
    output logic [Addr_size-1:0]              ram_addr,
    output logic [Word_size-1:0]              ram_din,
    output logic                              ram_we,
    output logic                              ram_re,
    input  logic [Word_size-1:0]              ram_dout,
    output logic                              busy,
    output logic                              done,
    output logic                              fail,
    output logic [Addr_size-1:0]              fail_addr,
    output logic [$clog2(Num_patterns)-1:0]   fail_pat
);

    localparam int unsigned PW = $clog2(Num_patterns);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] CMP   = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
`ifdef BIST_ABORT_ON_FAIL_EN
    localparam logic [2:0] FLUSH = 3'd6;
`endif

    localparam logic [Addr_size-1:0] ADDR_MAX = '1;
    localparam logic [PW-1:0]        PAT_MAX  = PW'(Num_patterns - 1);

    logic [2:0]           state;
    logic [Addr_size-1:0] addr;
    logic [PW-1:0]        pat;
    logic [PW-1:0]        pat_inc;
    logic                 addr_last;
    logic                 mismatch;

    always_comb begin
        addr_last = (addr == ADDR_MAX);
        pat_inc   = (pat == PAT_MAX) ? '0 : pat + 1'b1;
        mismatch  = (ram_dout != word);
    end

    always_comb begin
        ram_addr = addr;
        ram_din  = word;
        ram_we   = (state == WRITE);
        ram_re   = (state == READ);
        done     = (state == DONE);
        busy     = (state != IDLE) && (state != DONE);
    end

    // gen_next is set on the edge entering NEXT/FLUSH so it is a clean registered pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            pat       <= '0;
            gen_next  <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_pat  <= '0;
        end else begin
            gen_next <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_pat  <= '0;
                        addr      <= '0;
                        pat       <= '0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (addr_last) begin
                        addr  <= '0;
                        state <= READ;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                READ: state <= CMP;
                CMP: begin
                    if (mismatch && !fail) begin
                        fail      <= 1'b1;
                        fail_addr <= addr;
                        fail_pat  <= pat;
                    end
`ifdef BIST_ABORT_ON_FAIL_EN
                    if (mismatch) begin
                        addr     <= '0;
                        pat      <= pat_inc;
                        gen_next <= 1'b1;
                        state    <= FLUSH;
                    end else
`endif
                    if (addr_last) begin
                        addr     <= '0;
                        gen_next <= 1'b1;
                        state    <= NEXT;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= READ;
                    end
                end
                NEXT: begin
                    pat   <= pat_inc;
                    state <= (pat == PAT_MAX) ? DONE : WRITE;
                end
`ifdef BIST_ABORT_ON_FAIL_EN
                // pat already counts the pulse currently on gen_next; leave once it has wrapped
                FLUSH: begin
                    if (gen_next) begin
                        if (pat == '0)
                            state <= DONE;
                    end else begin
                        gen_next <= 1'b1;
                        pat      <= pat_inc;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bist_march_ctrl.md
Name: bist_march_ctrl

Overview:
- Sequencing controller for the RAM BIST path. Drives the word pattern generator through its `gen_next` strobe.
- For each generated pattern, it writes the pattern to every RAM address, then reads every address back and compares it against the same pattern.
- Reports `busy`/`done`, a sticky `fail` flag, and the first failing address and pattern index.
- Sits between the BIST top level (start/status) and the RAM plus word generator.

Parameters:
- Word_size, 3, data width of RAM word and generator output
- Addr_size, 4, RAM address width; the test covers 2**Addr_size locations
- Num_patterns, 4, generator patterns per run; must equal the generator sequence length so the generator wraps back to pattern 0 at end of run

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a run; sampled in IDLE or DONE only
- word  input  Word_size  current test word from the generator
- gen_next  output  1  registered strobe to the generator; one high cycle advances it one pattern
- ram_addr  output  Addr_size  RAM address
- ram_din  output  Word_size  RAM write data; equals `word` combinationally
- ram_we  output  1  RAM write enable; write takes effect at the clk edge
- ram_re  output  1  RAM read enable; synchronous read, `ram_dout` is valid the cycle after `ram_re`
- ram_dout  input  Word_size  RAM read data
- busy  output  1  high from the cycle after an accepted start until DONE
- done  output  1  high while in DONE
- fail  output  1  sticky mismatch flag; cleared by reset or an accepted start
- fail_addr  output  Addr_size  address of the first mismatch
- fail_pat  output  clog2(Num_patterns)  pattern index of the first mismatch

Behaviour:
- Reset values:
  - state = IDLE.
  - Outputs `gen_next`, `ram_we`, `ram_re`, `busy`, `done`, `fail` = 0.
  - `ram_addr`, `fail_addr`, `fail_pat` = 0.
  - Internal address counter and pattern index pat = 0.
- The generator has no reset. The controller requires the generator at pattern 0 when a run starts. Every completed run issues exactly Num_patterns `gen_next` pulses to preserve this.
- States: IDLE, WRITE, READ, CMP, NEXT, DONE (plus FLUSH with the optional feature).
- IDLE/DONE, start=1:
  - clear `fail`, `fail_addr`, `fail_pat`, addr, pat;
  - go to WRITE.
  - `start` in any other state is ignored.
- WRITE:
  - `ram_we`=1, `ram_addr`=addr.
  - If addr is at its maximum, set addr=0 and go to READ; otherwise addr+1.
- READ:
  - `ram_re`=1, `ram_addr`=addr; go to CMP.
- CMP:
  - Compare `ram_dout` against `word`.
  - On mismatch with `fail`=0: set `fail`=1, capture `fail_addr`=addr and `fail_pat`=pat.
  - Later mismatches do not update the captured values.
  - If addr is at its maximum, set addr=0 and go to NEXT; otherwise addr+1 and go to READ.
- NEXT:
  - `gen_next`=1 for exactly one cycle, pat+1.
  - If pat was Num_patterns-1, set pat=0 and go to DONE; otherwise go to WRITE.
  - The generator updates on the `gen_next` rising edge, so `word` is stable before the next WRITE cycle.
- DONE:
  - `done`=1, `busy`=0. Hold until reset or start.
- Run length: Num_patterns × (3 × 2**Addr_size + 1) cycles in WRITE..NEXT; 196 cycles with defaults. `done` rises on cycle 197 after the start-accept edge.
- Address counter wraps naturally at 2**Addr_size; there is no out-of-range address.
- Reset mid-run: all outputs return to reset values immediately (asynchronously). Generator phase is not restored; re-initialising the generator is the system reset's responsibility.
- `ram_we` and `ram_re` are never high in the same cycle.

Optional Feature:
- Macro: BIST_ABORT_ON_FAIL_EN.
- Defined:
  - On the first mismatch in CMP, skip the remaining addresses and patterns and go to FLUSH.
  - FLUSH pulses `gen_next` in alternating high/low cycles, incrementing pat on each pulse, until pat wraps to 0. It then goes to DONE, leaving the generator at pattern 0.
- Not defined: FLUSH does not exist; the run always completes and `fail` only records the first mismatch.

Test Plan:
- Fault-free RAM model, defaults:
  - start pulse -> `busy`=1 next cycle;
  - writes of 010, 111, 011, 100 in pattern order, with reads returning the same values;
  - exactly 4 `gen_next` pulses;
  - `done`=1 on cycle 197 with `fail`=0.
- Stuck-at fault forcing `ram_dout`=000 at addr 5 during pattern 1 -> `fail`=1, `fail_addr`=5, `fail_pat`=1, run still ends with `done`=1.
- Two injected faults (addr 3 pattern 0, addr 9 pattern 2) -> `fail_addr`=3 and `fail_pat`=0 retained.
- `start` pulsed during WRITE and READ -> ignored; `start` in DONE -> `fail` cleared and a new 196-cycle run begins with `word`=010.
- Reset asserted mid-READ -> all outputs 0 asynchronously, state IDLE; after release, start runs a clean pass (generator re-initialised by the bench).
- With BIST_ABORT_ON_FAIL_EN and a fault at addr 2 pattern 0 -> FLUSH emits 4 `gen_next` pulses total, then `done`=1, `fail_addr`=2, and `word`=010 afterwards.
